// File: rtl/addsub_acc_ctrl.sv
// Accumulator controller for an external 4-bit add/sub stage: accepts one
// command at a time, drives the adder operands, then holds the result and flags until consumed.
module addsub_acc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [3:0] operand,
  output logic [3:0] rca_a,
  output logic [3:0] rca_b,
  output logic       rca_sub,
  input  logic [3:0] rca_s,
  input  logic       rca_cout,
  input  logic       rca_cfout,
  output logic [3:0] acc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v,
  output logic       flag_c
);

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_op;
  logic [3:0] r_operand;
  logic       r_sub;
  logic [3:0] r_acc;
  logic       r_flag_z;
  logic       r_flag_n;
  logic       r_flag_v;
  logic       r_flag_c;
  logic       w_accept;
  logic [3:0] w_b_eff;
  logic       w_ovf;
  logic [3:0] w_acc_nxt;
  logic       w_v_nxt;
  logic       w_c_nxt;

  assign w_accept = in_valid && (r_state == S_IDLE);
  // The adder sees the operand inverted on subtract; overflow is judged on that effective B.
  assign w_b_eff  = r_operand ^ {4{r_sub}};
  assign w_ovf    = (r_acc[3] == w_b_eff[3]) && (rca_s[3] != r_acc[3]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_RESP);
    rca_a     = r_acc;
    rca_b     = r_operand;
    rca_sub   = r_sub;
    acc       = r_acc;
    flag_z    = r_flag_z;
    flag_n    = r_flag_n;
    flag_v    = r_flag_v;
    flag_c    = r_flag_c;
  end

  // Command capture; operand registers double as the held rca_b/rca_sub drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_ADD;
      r_operand <= 4'd0;
      r_sub     <= 1'b0;
    end else if (w_accept) begin
      r_op      <= op;
      r_operand <= operand;
      r_sub     <= (op == OP_SUB);
    end else begin
      r_op      <= r_op;
      r_operand <= r_operand;
      r_sub     <= r_sub;
    end
  end

  // Result selection per command
  always_comb begin
    w_acc_nxt = r_acc;
    w_v_nxt   = 1'b0;
    w_c_nxt   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_acc_nxt = rca_s;
        w_v_nxt   = w_ovf;
        w_c_nxt   = rca_cfout;
      end
      OP_SUB: begin
        w_acc_nxt = rca_s;
        w_v_nxt   = w_ovf;
        w_c_nxt   = ~rca_cout;
      end
      OP_LOAD:  w_acc_nxt = r_operand;
      OP_CLEAR: w_acc_nxt = 4'd0;
      default:  w_acc_nxt = 4'd0;
    endcase
  end

  // Accumulator and flags commit on the edge leaving EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= 4'd0;
      r_flag_z <= 1'b1;
      r_flag_n <= 1'b0;
      r_flag_v <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_acc    <= w_acc_nxt;
      r_flag_z <= (w_acc_nxt == 4'd0);
      r_flag_n <= w_acc_nxt[3];
      r_flag_v <= w_v_nxt;
      r_flag_c <= w_c_nxt;
    end else begin
      r_acc    <= r_acc;
      r_flag_z <= r_flag_z;
      r_flag_n <= r_flag_n;
      r_flag_v <= r_flag_v;
      r_flag_c <= r_flag_c;
    end
  end

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Self-checking bench for addsub_acc_ctrl: behavioural adder stage, directed
// cases and randomized commands compared against a signed-arithmetic model.
module tb_addsub_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [3:0] operand;
  logic [3:0] rca_a;
  logic [3:0] rca_b;
  logic       rca_sub;
  logic [3:0] rca_s;
  logic       rca_cout;
  logic       rca_cfout;
  logic [3:0] acc;
  logic       out_valid;
  logic       out_ready;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;
  logic       flag_c;

  int checks   = 0;
  int failures = 0;
  int m_acc, m_z, m_n, m_v, m_c;

  addsub_acc_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand(operand), .rca_a(rca_a), .rca_b(rca_b),
    .rca_sub(rca_sub), .rca_s(rca_s), .rca_cout(rca_cout),
    .rca_cfout(rca_cfout), .acc(acc), .out_valid(out_valid),
    .out_ready(out_ready), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // External 4-bit ripple add/sub stage: a + (b ^ sub) + sub
  logic [4:0] adder_sum;
  assign adder_sum = {1'b0, rca_a} + {1'b0, rca_b ^ {4{rca_sub}}} + {4'd0, rca_sub};
  assign rca_s     = adder_sum[3:0];
  assign rca_cout  = adder_sum[4];
  assign rca_cfout = adder_sum[4] & ~rca_sub;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sx(input int x);
    return (x > 7) ? x - 16 : x;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_z = 1; m_n = 0; m_v = 0; m_c = 0;
  endtask

  task automatic model_apply(input int o, input int d);
    int s;
    case (o)
      0: begin
        s = sx(m_acc) + sx(d);
        m_c = ((m_acc + d) > 15) ? 1 : 0;
        m_v = (s > 7 || s < -8) ? 1 : 0;
        m_acc = (m_acc + d) % 16;
      end
      1: begin
        s = sx(m_acc) - sx(d);
        m_c = (m_acc < d) ? 1 : 0;
        m_v = (s > 7 || s < -8) ? 1 : 0;
        m_acc = (m_acc - d + 16) % 16;
      end
      2: begin m_acc = d; m_c = 0; m_v = 0; end
      default: begin m_acc = 0; m_c = 0; m_v = 0; end
    endcase
    m_z = (m_acc == 0) ? 1 : 0;
    m_n = (m_acc >= 8) ? 1 : 0;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_acc"}, acc, m_acc);
    check({tag, "_z"}, flag_z, m_z);
    check({tag, "_n"}, flag_n, m_n);
    check({tag, "_v"}, flag_v, m_v);
    check({tag, "_c"}, flag_c, m_c);
  endtask

  // Issue one command from a negedge; returns at the negedge after release.
  task automatic run_cmd(input int o, input int d, input int bp, input logic iv_hold);
    int w;
    int old_acc;
    op = o[1:0]; operand = d[3:0]; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", in_ready, 1'b1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    old_acc = m_acc;
    @(posedge clk);
    @(negedge clk);
    in_valid = iv_hold; op = 2'($urandom); operand = 4'($urandom);
    check("exec_in_ready", in_ready, 1'b0);
    check("exec_out_valid", out_valid, 1'b0);
    check("exec_rca_a", rca_a, old_acc);
    check("exec_rca_b", rca_b, d);
    check("exec_rca_sub", rca_sub, (o == 1));
    check("exec_acc_held", acc, old_acc);
    model_apply(o, d);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = (bp == 0);
    check("resp_out_valid", out_valid, 1'b1);
    check("resp_in_ready", in_ready, 1'b0);
    check("resp_rca_a", rca_a, m_acc);
    check_result("resp");
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_rca_b", rca_b, d);
      check("hold_rca_sub", rca_sub, (o == 1));
      check_result("hold");
      if (i == bp - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("rel_out_valid", out_valid, 1'b0);
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_acc", acc, m_acc);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_acc"}, acc, 4'd0);
    check({tag, "_z"}, flag_z, 1'b1);
    check({tag, "_nvc"}, {flag_n, flag_v, flag_c}, 3'd0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_rca"}, {rca_a, rca_b, rca_sub}, 9'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; operand = 4'd0;
    model_reset();
    #2;
    check_reset_state("reset0");
    @(negedge clk);
    rst = 1'b0;

    run_cmd(2, 5, 0, 1'b0);
    run_cmd(0, 3, 0, 1'b0);
    check("add53_acc_const", acc, 4'd8);
    check("add53_flags_const", {flag_z, flag_n, flag_v, flag_c}, 4'b0110);
    run_cmd(2, 3, 0, 1'b0);
    run_cmd(1, 5, 0, 1'b0);
    check("sub35_acc_const", acc, 4'hE);
    check("sub35_flags_const", {flag_z, flag_n, flag_v, flag_c}, 4'b0101);
    run_cmd(2, 15, 0, 1'b0);
    run_cmd(0, 1, 0, 1'b0);
    check("addf1_flags_const", {flag_z, flag_n, flag_v, flag_c}, 4'b1001);
    run_cmd(2, 8, 0, 1'b0);
    run_cmd(1, 1, 5, 1'b1);
    check("sub81_acc_const", acc, 4'd7);
    check("sub81_vc_const", {flag_v, flag_c}, 2'b10);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1 check_reset_state("reset_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset during EXEC of ADD 3 on acc=5 aborts it
    run_cmd(2, 5, 0, 1'b0);
    op = 2'd0; operand = 4'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_in_exec", out_valid, 1'b0);
    #1 rst = 1'b1;
    #1 check_reset_state("reset_exec");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_cmd(3, 0, 1, 1'b1);
    check("clear_z_const", flag_z, 1'b1);

    for (int n = 0; n < 60; n++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
